// File: rtl/pump_signal_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pump_signal_if
// Brief   : Key-emulation bus between the auto-load sequencer and its parent.
// Revision: 1.0 - initial release
// ============================================================================
interface pump_signal_if;
    logic       download_i;
    logic [7:0] pump_o;
    logic       loading_o;
    logic       done_o;

    modport master (
        output download_i,
        input  pump_o,
        input  loading_o,
        input  done_o
    );

    modport slave (
        input  download_i,
        output pump_o,
        output loading_o,
        output done_o
    );
endinterface
`default_nettype wire

// File: rtl/pump_signal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pump_signal
// Brief   : Power-up auto-load sequencer: emulates a front-panel key press after
//           PLL lock, tracks the ROM download, then releases the key bus for good.
//           Optional macro PUMP_RETRY_EN re-presses after an ARMED timeout.
// Revision: 1.0 - initial release
// ============================================================================
module pump_signal #(
    parameter int         DELAY_CYCLES   = 1024,
    parameter int         PULSE_CYCLES   = 256,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         MAX_RETRIES    = 3,
    parameter logic [7:0] KEY_MASK       = 8'h01
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    pump_signal_if.slave   bus
);

    localparam int c_MAX_LIM_A = (DELAY_CYCLES > PULSE_CYCLES) ? DELAY_CYCLES : PULSE_CYCLES;
    localparam int c_MAX_LIM   = (c_MAX_LIM_A > TIMEOUT_CYCLES) ? c_MAX_LIM_A : TIMEOUT_CYCLES;
    localparam int c_CNT_W     = (c_MAX_LIM > 1) ? $clog2(c_MAX_LIM) : 1;

    localparam logic [c_CNT_W-1:0] c_DELAY_LAST   = c_CNT_W'(DELAY_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST   = c_CNT_W'(PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         c_KEY_IDLE     = 8'hFF;
    localparam logic [7:0]         c_KEY_PRESS    = ~KEY_MASK;

    generate
        if (DELAY_CYCLES < 1 || PULSE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || MAX_RETRIES < 0) begin : g_bad_params
            $error("pump_signal: cycle counts must be >= 1 and MAX_RETRIES >= 0");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_PRESS   = 3'd1,
        S_ARMED   = 3'd2,
        S_LOADING = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_pump;
    logic                 r_loading;
    logic                 r_done;
    logic                 r_dl_meta;
    logic                 r_dl_s;
    logic                 w_pre_load;

`ifdef PUMP_RETRY_EN
    localparam int                c_RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [c_RTY_W-1:0] c_RTY_MAX = c_RTY_W'(MAX_RETRIES);
    logic [c_RTY_W-1:0]           r_retry;
`endif

    // download_i comes from the IO controller's clock domain
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_meta <= 1'b0;
            r_dl_s    <= 1'b0;
        end else begin
            r_dl_meta <= bus.download_i;
            r_dl_s    <= r_dl_meta;
        end
    end

    // Any state that has not yet seen the download may still be pre-empted by it
    assign w_pre_load = (r_state == S_WAIT) || (r_state == S_PRESS) || (r_state == S_ARMED);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_WAIT;
            r_cnt     <= '0;
            r_pump    <= c_KEY_IDLE;
            r_loading <= 1'b0;
            r_done    <= 1'b0;
`ifdef PUMP_RETRY_EN
            r_retry   <= '0;
`endif
        end else if (w_pre_load && r_dl_s) begin
            r_state   <= S_LOADING;
            r_cnt     <= '0;
            r_pump    <= c_KEY_IDLE;
            r_loading <= 1'b1;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == c_DELAY_LAST) begin
                        r_state <= S_PRESS;
                        r_cnt   <= '0;
                        r_pump  <= c_KEY_PRESS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_PRESS: begin
                    if (r_cnt == c_PULSE_LAST) begin
                        r_state <= S_ARMED;
                        r_cnt   <= '0;
                        r_pump  <= c_KEY_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_ARMED: begin
                    if (r_cnt == c_TIMEOUT_LAST) begin
                        r_cnt <= '0;
`ifdef PUMP_RETRY_EN
                        if (r_retry < c_RTY_MAX) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= S_PRESS;
                            r_pump  <= c_KEY_PRESS;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
`else
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_LOADING: begin
                    if (!r_dl_s) begin
                        r_state   <= S_DONE;
                        r_loading <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end

                S_DONE: begin
                    // Terminal: later download activity must never re-press the key
                    r_state <= S_DONE;
                end

                default: begin
                    r_state   <= S_WAIT;
                    r_cnt     <= '0;
                    r_pump    <= c_KEY_IDLE;
                    r_loading <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pump_o    = r_pump;
    assign bus.loading_o = r_loading;
    assign bus.done_o    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pump_signal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_pump_signal
// Brief   : Scoreboard bench for pump_signal; expected output-change events are
//           queued with each scenario and matched as the outputs change.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pump_signal;

    localparam int P_DELAY   = 4;
    localparam int P_PULSE   = 3;
    localparam int P_TIMEOUT = 8;
    localparam int P_RETRIES = 2;

`ifdef PUMP_RETRY_EN
    localparam int c_IDLE_DONE = 37;
`else
    localparam int c_IDLE_DONE = 15;
`endif

    typedef struct {
        string      tag;
        int         cyc;
        logic [9:0] val;
    } ev_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    bit         mon_en = 1'b0;
    int         cyc    = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] prev_obs = 10'h3FC;
    ev_t        exp_q[$];

    pump_signal_if pif();

    pump_signal #(
        .DELAY_CYCLES   (P_DELAY),
        .PULSE_CYCLES   (P_PULSE),
        .TIMEOUT_CYCLES (P_TIMEOUT),
        .MAX_RETRIES    (P_RETRIES),
        .KEY_MASK       (8'h01)
    ) u_dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (pif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic exp_ev(input string tag, input int c, input logic [7:0] p, input logic l, input logic d);
        ev_t e;
        e.tag = tag;
        e.cyc = c;
        e.val = {p, l, d};
        exp_q.push_back(e);
    endtask

    // Every change of {pump,loading,done} must match the next queued event
    always @(negedge clk) begin : mon
        logic [9:0] obs;
        ev_t        e;
        obs = {pif.pump_o, pif.loading_o, pif.done_o};
        if (!mon_en || !rst_n) begin
            prev_obs = 10'h3FC;
        end else if (obs !== prev_obs) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_change", {22'd0, obs}, {22'd0, prev_obs});
            end else begin
                e = exp_q.pop_front();
                check_eq({e.tag, "_cyc"}, cyc, e.cyc);
                check_eq({e.tag, "_val"}, {22'd0, obs}, {22'd0, e.val});
            end
            prev_obs = obs;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        pif.download_i = 1'b0;
        #1;
        check_eq("rst_pump",    pif.pump_o,    8'hFF);
        check_eq("rst_loading", pif.loading_o, 1'b0);
        check_eq("rst_done",    pif.done_o,    1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) check_eq("wait_bound", cyc, n);
    endtask

    task automatic finish_scn(input string tag, input int settle);
        repeat (settle) @(negedge clk);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic push_idle();
        exp_ev("press1_on",  4, 8'hFE, 1'b0, 1'b0);
        exp_ev("press1_off", 7, 8'hFF, 1'b0, 1'b0);
`ifdef PUMP_RETRY_EN
        exp_ev("press2_on",  15, 8'hFE, 1'b0, 1'b0);
        exp_ev("press2_off", 18, 8'hFF, 1'b0, 1'b0);
        exp_ev("press3_on",  26, 8'hFE, 1'b0, 1'b0);
        exp_ev("press3_off", 29, 8'hFF, 1'b0, 1'b0);
`endif
        exp_ev("idle_done", c_IDLE_DONE, 8'hFF, 1'b0, 1'b1);
    endtask

    initial begin
        pif.download_i = 1'b0;

        // No download: press sequence then timeout to DONE
        apply_reset();
        push_idle();
        finish_scn("idle", c_IDLE_DONE + 25);
        check_eq("idle_final_done", pif.done_o, 1'b1);
        check_eq("idle_final_pump", pif.pump_o, 8'hFF);

        // Download activity after DONE is ignored
        pif.download_i = 1'b1;
        repeat (5) @(negedge clk);
        pif.download_i = 1'b0;
        finish_scn("post_done", 20);
        check_eq("post_done_done", pif.done_o,    1'b1);
        check_eq("post_done_pump", pif.pump_o,    8'hFF);
        check_eq("post_done_load", pif.loading_o, 1'b0);

        // Normal download after the press
        apply_reset();
        exp_ev("dl_press_on",  4,  8'hFE, 1'b0, 1'b0);
        exp_ev("dl_press_off", 7,  8'hFF, 1'b0, 1'b0);
        exp_ev("dl_load_rise", 11, 8'hFF, 1'b1, 1'b0);
        exp_ev("dl_done",      31, 8'hFF, 1'b0, 1'b1);
        wait_cyc(8);
        pif.download_i = 1'b1;
        wait_cyc(28);
        pif.download_i = 1'b0;
        finish_scn("download", 20);

        // Download raised in the second press cycle
        apply_reset();
        exp_ev("p2_press_on",  4,  8'hFE, 1'b0, 1'b0);
        exp_ev("p2_press_off", 7,  8'hFF, 1'b0, 1'b0);
        exp_ev("p2_load_rise", 8,  8'hFF, 1'b1, 1'b0);
        exp_ev("p2_done",      18, 8'hFF, 1'b0, 1'b1);
        wait_cyc(5);
        pif.download_i = 1'b1;
        wait_cyc(15);
        pif.download_i = 1'b0;
        finish_scn("press2_dl", 30);

        // Download seen mid-press aborts the pulse after two cycles
        apply_reset();
        exp_ev("ab_press_on", 4,  8'hFE, 1'b0, 1'b0);
        exp_ev("ab_abort",    6,  8'hFF, 1'b1, 1'b0);
        exp_ev("ab_done",     15, 8'hFF, 1'b0, 1'b1);
        wait_cyc(3);
        pif.download_i = 1'b1;
        wait_cyc(12);
        pif.download_i = 1'b0;
        finish_scn("abort", 40);

        // Reset mid-press, then the whole sequence restarts
        apply_reset();
        exp_ev("mr_press_on", 4, 8'hFE, 1'b0, 1'b0);
        wait_cyc(5);
        check_eq("mr_pump_low", pif.pump_o, 8'hFE);
        check_eq("mr_pending", exp_q.size(), 0);
        apply_reset();
        push_idle();
        finish_scn("restart", c_IDLE_DONE + 25);
        check_eq("restart_done", pif.done_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pump_signal.md
Name: pump_signal

Overview:
- Power-up auto-load sequencer for the Multicore 2 frame.
- After PLL lock it emulates an active-low front-panel key press on an 8-bit key bus. This makes the IO controller start the ROM download.
- It then tracks the download and releases the bus permanently once the download completes.
- The output is ANDed with the physical key bus before it reaches the data_io key input.

Parameters:
- DELAY_CYCLES, 1024: idle cycles after reset release before the first press; must be ≥1.
- PULSE_CYCLES, 256: cycles the emulated key is held low; must be ≥1.
- TIMEOUT_CYCLES, 4096: cycles to wait for the download to start after a press; must be ≥1.
- MAX_RETRIES, 3: extra presses allowed after the first (used only with PUMP_RETRY_EN).
- KEY_MASK, 8'h01: bits driven low during a press.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset; the parent drives it from pll_locked.
- download_i  in  1  ROM download active, from another clock domain.
- pump_o  out  8  active-low key emulation; 8'hFF means no key pressed.
- loading_o  out  1  high while the download is in progress.
- done_o  out  1  high once the sequence has finished (sticky).

Behaviour:
- download_i passes through a 2-flop synchronizer; dl_s is the synchronized value. All decisions use dl_s.
- All outputs are registered.
- Reset values: pump_o=8'hFF, loading_o=0, done_o=0, state=WAIT, counter=0, retry count=0, synchronizer flops=0.
- One counter is shared by all states. It increments each cycle in WAIT, PRESS and ARMED. When it reaches its limit minus 1, the state changes and the counter clears.
- WAIT: pump_o=FF. After DELAY_CYCLES cycles, go to PRESS.
  - First low pump_o is visible after rising edge number DELAY_CYCLES following reset release.
- PRESS: pump_o = ~KEY_MASK. After PULSE_CYCLES cycles, go to ARMED with pump_o=FF.
  - Exactly PULSE_CYCLES cycles of low output.
- ARMED: pump_o=FF. If dl_s=1, go to LOADING. If the counter reaches TIMEOUT_CYCLES-1, go to timeout handling.
- Timeout without PUMP_RETRY_EN: go to DONE.
- LOADING: pump_o=FF, loading_o=1. On dl_s=0, go to DONE.
- DONE: pump_o=FF, loading_o=0, done_o=1. Terminal until reset.
- dl_s=1 seen in WAIT, PRESS or ARMED goes to LOADING on the next edge. This aborts any press in progress: pump_o returns to FF on that same edge and the counter clears.
- dl_s=1 while already in DONE is ignored. No second press occurs.
- rst_n asserted in any state returns everything to reset values immediately, including mid-press: pump_o becomes FF asynchronously.
- No other glitches: pump_o changes only on state transitions.

Optional Feature:
- Macro: PUMP_RETRY_EN.
- Defined:
  - ARMED timeout with retry count < MAX_RETRIES: increment the retry count, go to PRESS for a fresh PULSE_CYCLES press.
  - Retry count = MAX_RETRIES: go to DONE.
  - Total presses are at most MAX_RETRIES+1.
- Undefined:
  - Single press; the ARMED timeout goes straight to DONE.
  - The retry counter and MAX_RETRIES logic are absent.

Test Plan (DELAY=4, PULSE=3, TIMEOUT=8, MAX_RETRIES=2, KEY_MASK=8'h01):
- Release rst_n, keep download_i=0 → pump_o=FF for 4 edges, then 8'hFE for exactly 3 cycles, then FF. Without the macro, done_o=1 after 8 further cycles and no further presses occur.
- After the press, raise download_i for 20 cycles then drop it → loading_o rises 2–3 cycles after the rise, pump_o stays FF. loading_o falls and done_o rises 2–3 cycles after the fall.
- Raise download_i during the second PRESS cycle → pump_o returns to FF within 3 edges and loading_o=1. After download_i falls, done_o=1 and no further presses occur.
- With PUMP_RETRY_EN and download_i held 0 → exactly 3 presses of 3 cycles each, separated by 8-cycle ARMED windows, then done_o=1 and pump_o=FF permanently.
- Assert rst_n=0 mid-press → pump_o=FF and done_o=0 asynchronously. After release, the full sequence restarts from WAIT.
- Pulse download_i after done_o=1 → pump_o stays FF and done_o stays 1.
